mem_access_responder: RTL and testbench

- Responder side of the MEM-stage memory handshake: accepts one load/store request per instruction from the stage sequencing logic.
- Drives a synchronous word-wide data RAM with byte enables and waits out the RAM read latency.
- Returns a single-cycle `resp_valid` pulse with aligned, extended load data or an alignment error.
- Lets the stage sequencer wait on completion instead of assuming a fixed MEM/MEM_WAIT slot.

---
 rtl/mem_access_responder.sv | 236 +++++++++++++++++++++++
 tb/tb_mem_access_responder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_responder.sv
// ----------------------------------------------------------------------------
// mem_access_responder
//
// Responder side of the MEM-stage load/store handshake. Accepts one request
// while idle, drives a synchronous word-wide data RAM (byte enables, lane-
// replicated write data), waits out the RAM read latency, and returns a
// single-cycle resp_valid pulse. The pulse carries either the aligned and
// extended load data or an alignment error. All outputs are registered.
//
// Ports
//   clk, reset      : clock, asynchronous active-high reset
//   req_valid       : request strobe from the MEM stage
//   req_ready       : high only while idle; accept = req_valid && req_ready
//   req_wren        : 1 = store, 0 = load
//   req_size        : 0 = byte, 1 = half, 2/3 = word
//   req_signed      : loads only, 1 = sign-extend, 0 = zero-extend
//   req_addr        : byte address (bits above RAM_AW+1 are ignored)
//   req_wdata       : right-aligned store data
//   resp_valid      : one-cycle completion pulse
//   resp_rdata      : load result, 0 for stores and errors, held until next
//   resp_err        : misaligned access, held until next response
//   ram_addr        : RAM word index
//   ram_wdata       : lane-replicated store data
//   ram_we          : per-byte write enables
//   ram_rdata       : RAM read data, valid RAM_LATENCY cycles after ram_addr
// ----------------------------------------------------------------------------
module mem_access_responder #(
    parameter int ADDR_W      = 32,
    parameter int RAM_AW      = 14,
    parameter int RAM_LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wren,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic [3:0]        ram_we,
    input  logic [31:0]       ram_rdata
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITE     = 2'd1,
        READ_WAIT = 2'd2,
        RESP      = 2'd3
    } state_e;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;

    localparam int                CNT_W    = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;
    localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(RAM_LATENCY - 1);

    state_e              state_q,      state_d;
    logic [CNT_W-1:0]    cnt_q,        cnt_d;
    logic [1:0]          size_q,       size_d;
    logic                signed_q,     signed_d;
    logic [1:0]          lane_q,       lane_d;
    logic                req_ready_q,  req_ready_d;
    logic                resp_valid_q, resp_valid_d;
    logic [31:0]         resp_rdata_q, resp_rdata_d;
    logic                resp_err_q,   resp_err_d;
    logic [RAM_AW-1:0]   ram_addr_q,   ram_addr_d;
    logic [31:0]         ram_wdata_q,  ram_wdata_d;
    logic [3:0]          ram_we_q,     ram_we_d;

    // Upper address bits select nothing: the RAM index wraps modulo 2^RAM_AW.
    generate
        if (ADDR_W > RAM_AW + 2) begin : g_unused_addr
            logic unused_addr_hi;
            assign unused_addr_hi = ^req_addr[ADDR_W-1:RAM_AW+2];
        end
    endgenerate

    // Size 3 behaves exactly like a word access.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lsb);
        case (size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = lsb[0];
            default: misaligned = (lsb != 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] store_we(input logic [1:0] size, input logic [1:0] lsb);
        case (size)
            SZ_BYTE: store_we = 4'(4'b0001 << lsb);
            SZ_HALF: store_we = 4'(4'b0011 << lsb);
            default: store_we = 4'b1111;
        endcase
    endfunction

    // Replicating the data across all lanes lets the byte enables alone pick
    // the destination bytes inside the RAM word.
    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            SZ_BYTE: store_data = {4{wdata[7:0]}};
            SZ_HALF: store_data = {2{wdata[15:0]}};
            default: store_data = wdata;
        endcase
    endfunction

    function automatic logic [31:0] load_data(input logic [1:0]  size,
                                              input logic [1:0]  lsb,
                                              input logic        sgn,
                                              input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lsb, 3'b000} +: 8];
        h = lsb[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: load_data = {{24{sgn & b[7]}}, b};
            SZ_HALF: load_data = {{16{sgn & h[15]}}, h};
            default: load_data = word;
        endcase
    endfunction

    // NOTE: every variable gets its default before the case statement, so no
    // path through this block can leave a value unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        size_d       = size_q;
        signed_d     = signed_q;
        lane_d       = lane_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        ram_we_d     = 4'b0000;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    size_d   = req_size;
                    signed_d = req_signed;
                    lane_d   = req_addr[1:0];
                    if (misaligned(req_size, req_addr[1:0])) begin
                        // Error responses skip the RAM entirely.
                        state_d      = RESP;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 32'h0;
                    end else if (req_wren) begin
                        state_d     = WRITE;
                        ram_addr_d  = req_addr[RAM_AW+1:2];
                        ram_we_d    = store_we(req_size, req_addr[1:0]);
                        ram_wdata_d = store_data(req_size, req_wdata);
                    end else begin
                        state_d    = READ_WAIT;
                        ram_addr_d = req_addr[RAM_AW+1:2];
                        cnt_d      = CNT_INIT;
                    end
                end
            end

            WRITE: begin
                state_d      = RESP;
                resp_err_d   = 1'b0;
                resp_rdata_d = 32'h0;
            end

            READ_WAIT: begin
                // ram_addr has been stable since the first READ_WAIT cycle, so
                // the count reaching zero marks the cycle ram_rdata is valid.
                if (cnt_q == '0) begin
                    state_d      = RESP;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = load_data(size_q, lane_q, signed_q, ram_rdata);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Handshake flags follow the next state so they line up with it.
        req_ready_d  = (state_d == IDLE);
        resp_valid_d = (state_d == RESP);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            size_q       <= 2'b00;
            signed_q     <= 1'b0;
            lane_q       <= 2'b00;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= 32'h0;
            ram_we_q     <= 4'b0000;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            lane_q       <= lane_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            ram_we_q     <= ram_we_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign ram_addr   = ram_addr_q;
    assign ram_wdata  = ram_wdata_q;
    assign ram_we     = ram_we_q;

endmodule

// File: tb/tb_mem_access_responder.sv
// ----------------------------------------------------------------------------
// tb_mem_access_responder
//
// Directed bench for mem_access_responder with RAM_LATENCY=2. A behavioural
// byte-enabled RAM with one internal register stage sits on the RAM port, so
// read data for an address presented in cycle T+1 is visible in T+2.
// ----------------------------------------------------------------------------
module tb_mem_access_responder;

    localparam int ADDR_W = 32;
    localparam int RAM_AW = 14;
    localparam int LAT    = 2;

    logic              clk;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic              req_wren;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [RAM_AW-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [3:0]        ram_we;
    logic [31:0]       ram_rdata;

    int n_checks = 0;
    int n_pass   = 0;

    mem_access_responder #(
        .ADDR_W      (ADDR_W),
        .RAM_AW      (RAM_AW),
        .RAM_LATENCY (LAT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wren   (req_wren),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_we     (ram_we),
        .ram_rdata  (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: byte-lane writes, one register stage on the read path.
    logic [31:0]       mem [0:(1<<RAM_AW)-1];
    logic [RAM_AW-1:0] rd_addr_q;

    initial begin
        for (int i = 0; i < (1 << RAM_AW); i++) mem[i] = 32'h0;
    end

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (ram_we[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
        rd_addr_q <= ram_addr;
    end
    assign ram_rdata = mem[rd_addr_q];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    endtask

    // One complete transaction. lat is the cycle (relative to the accept edge)
    // in which resp_valid must pulse; exp_we/exp_wdata describe the store cycle.
    task automatic run_req(input string       tag,
                           input logic        wren,
                           input logic [1:0]  size,
                           input logic        sgn,
                           input logic [31:0] addr,
                           input logic [31:0] wdata,
                           input int          lat,
                           input logic [31:0] exp_rdata,
                           input logic        exp_err,
                           input logic [3:0]  exp_we,
                           input logic [31:0] exp_wdata);
        logic early;
        logic we_seen;
        logic [31:0] idx;
        early   = 1'b0;
        we_seen = 1'b0;
        idx     = (addr >> 2) & 32'h0000_3FFF;
        @(negedge clk);
        check({tag, ".ready"}, req_ready, 1);
        req_valid  = 1'b1;
        req_wren   = wren;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            if (ram_we != 4'b0000) we_seen = 1'b1;
            if (k == 1 && !exp_err) check({tag, ".ram_addr"}, ram_addr, idx);
            if (k == 1 && wren && !exp_err) begin
                check({tag, ".ram_we"}, ram_we, exp_we);
                check({tag, ".ram_wdata"}, ram_wdata, exp_wdata);
            end
            if (k < lat && resp_valid) early = 1'b1;
        end
        check({tag, ".early_resp"}, early, 0);
        check({tag, ".resp_valid"}, resp_valid, 1);
        check({tag, ".resp_err"}, resp_err, exp_err);
        check({tag, ".resp_rdata"}, resp_rdata, exp_rdata);
        check({tag, ".we_at_resp"}, ram_we, 0);
        check({tag, ".we_seen"}, we_seen, (wren && !exp_err) ? 1 : 0);
        @(negedge clk);
        check({tag, ".resp_drop"}, resp_valid, 0);
        check({tag, ".rdata_hold"}, resp_rdata, exp_rdata);
    endtask

    // Reset asserted mid-cycle during T+1 of a request; outputs must clear at
    // once and the aborted request must never produce a response.
    task automatic abort_req(input string tag, input logic wren, input logic [31:0] addr);
        logic seen;
        seen = 1'b0;
        @(negedge clk);
        req_valid  = 1'b1;
        req_wren   = wren;
        req_size   = 2'd2;
        req_signed = 1'b0;
        req_addr   = addr;
        req_wdata  = 32'h1234_5678;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check({tag, ".busy"}, req_ready, 0);
        check({tag, ".we_before"}, ram_we, wren ? 4'b1111 : 4'b0000);
        #2 reset = 1'b1;
        #1;
        check({tag, ".rst_ready"}, req_ready, 1);
        check({tag, ".rst_we"}, ram_we, 0);
        check({tag, ".rst_addr"}, ram_addr, 0);
        check({tag, ".rst_valid"}, resp_valid, 0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (resp_valid) seen = 1'b1;
        end
        check({tag, ".no_resp"}, seen, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pulses;
        int first_k;
        int second_k;

        reset      = 1'b1;
        req_valid  = 1'b0;
        req_wren   = 1'b0;
        req_size   = 2'd0;
        req_signed = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;

        // Reset state, checked before the first clock edge.
        #3;
        check("rst.ready", req_ready, 1);
        check("rst.valid", resp_valid, 0);
        check("rst.err", resp_err, 0);
        check("rst.rdata", resp_rdata, 0);
        check("rst.we", ram_we, 0);
        check("rst.addr", ram_addr, 0);
        check("rst.wdata", ram_wdata, 0);
        #9 reset = 1'b0;

        //       tag        wren size sgn addr          wdata          lat  rdata          err  we       wdata
        run_req("st_w10",   1, 2'd2, 0, 32'h0000_0010, 32'hDEAD_BEEF, 2,   32'h0,         0, 4'b1111, 32'hDEAD_BEEF);
        run_req("ld_w10",   0, 2'd2, 0, 32'h0000_0010, 32'h0,         3,   32'hDEAD_BEEF, 0, 4'b0000, 32'h0);
        run_req("st_b13",   1, 2'd0, 0, 32'h0000_0013, 32'h0000_00A5, 2,   32'h0,         0, 4'b1000, 32'hA5A5_A5A5);
        run_req("ld_wrap",  0, 2'd2, 0, 32'h0001_0010, 32'h0,         3,   32'hA5AD_BEEF, 0, 4'b0000, 32'h0);
        run_req("st_w00",   1, 2'd2, 0, 32'h0000_0000, 32'h80FF_7F01, 2,   32'h0,         0, 4'b1111, 32'h80FF_7F01);
        run_req("ld_bs2",   0, 2'd0, 1, 32'h0000_0002, 32'h0,         3,   32'hFFFF_FFFF, 0, 4'b0000, 32'h0);
        run_req("ld_bs3",   0, 2'd0, 1, 32'h0000_0003, 32'h0,         3,   32'hFFFF_FF80, 0, 4'b0000, 32'h0);
        run_req("ld_bu3",   0, 2'd0, 0, 32'h0000_0003, 32'h0,         3,   32'h0000_0080, 0, 4'b0000, 32'h0);
        run_req("ld_bs1",   0, 2'd0, 1, 32'h0000_0001, 32'h0,         3,   32'h0000_007F, 0, 4'b0000, 32'h0);
        run_req("ld_hs2",   0, 2'd1, 1, 32'h0000_0002, 32'h0,         3,   32'hFFFF_80FF, 0, 4'b0000, 32'h0);
        run_req("ld_hu2",   0, 2'd1, 0, 32'h0000_0002, 32'h0,         3,   32'h0000_80FF, 0, 4'b0000, 32'h0);
        run_req("ld_hs0",   0, 2'd1, 1, 32'h0000_0000, 32'h0,         3,   32'h0000_7F01, 0, 4'b0000, 32'h0);
        run_req("st_h22",   1, 2'd1, 0, 32'h0000_0022, 32'h1234_ABCD, 2,   32'h0,         0, 4'b1100, 32'hABCD_ABCD);
        run_req("ld_w20",   0, 2'd2, 0, 32'h0000_0020, 32'h0,         3,   32'hABCD_0000, 0, 4'b0000, 32'h0);
        run_req("mis_w6",   0, 2'd2, 0, 32'h0000_0006, 32'h0,         1,   32'h0,         1, 4'b0000, 32'h0);
        run_req("mis_sh1",  1, 2'd1, 0, 32'h0000_0001, 32'hFFFF_FFFF, 1,   32'h0,         1, 4'b0000, 32'h0);
        run_req("ld_sz3",   0, 2'd3, 0, 32'h0000_0010, 32'h0,         3,   32'hA5AD_BEEF, 0, 4'b0000, 32'h0);

        // Idle reset clears held response data immediately.
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("idle_rst.rdata", resp_rdata, 0);
        check("idle_rst.ready", req_ready, 1);
        check("idle_rst.valid", resp_valid, 0);
        check("idle_rst.we", ram_we, 0);
        @(negedge clk);
        reset = 1'b0;

        // req_valid held high: exactly one response per accept, the second
        // accept lands on the edge right after the RESP cycle.
        @(negedge clk);
        req_valid  = 1'b1;
        req_wren   = 1'b0;
        req_size   = 2'd2;
        req_signed = 1'b0;
        req_addr   = 32'h0000_0000;
        @(posedge clk);
        pulses   = 0;
        first_k  = 0;
        second_k = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (resp_valid) begin
                pulses++;
                if (pulses == 1) first_k = k;
                if (pulses == 2) second_k = k;
            end
            if (k == 4) check("busy.ready_after_resp", req_ready, 1);
            if (k == 5) begin
                check("busy.second_accept", req_ready, 0);
                req_valid = 1'b0;
            end
        end
        check("busy.first_pulse", first_k, 3);
        check("busy.second_pulse", second_k, 7);
        check("busy.pulse_count", pulses, 2);
        check("busy.rdata", resp_rdata, 32'h80FF_7F01);

        // Aborts, then a normal request must still complete.
        abort_req("abort_rd", 1'b0, 32'h0000_0000);
        abort_req("abort_wr", 1'b1, 32'h0000_0030);
        run_req("ld_w30",   0, 2'd2, 0, 32'h0000_0030, 32'h0,         3,   32'h0,         0, 4'b0000, 32'h0);
        run_req("ld_after", 0, 2'd2, 0, 32'h0000_0000, 32'h0,         3,   32'h80FF_7F01, 0, 4'b0000, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
